// File: rtl/shared_onchip_memory_pkg.sv
// shared_onchip_memory_pkg: shared constants and types for the two-port shared memory.
package shared_onchip_memory_pkg;
    localparam int NUM_PORTS           = 2;
    localparam int READ_LATENCY_BASE   = 1;
    localparam int READ_LATENCY_OUTREG = 2;
    typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;
endpackage

// File: rtl/shared_onchip_memory_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter; the last accepted port loses the next tie.
module rr_arbiter2
    import shared_onchip_memory_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clken,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant
);
    port_idx_t prio;
    always_comb grant = !(reset_n && clken) ? '0 : (&req) ? (prio ? 2'b10 : 2'b01) : req;
    // grant is already qualified by clken, so any grant here is an accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prio <= '0;
        else if (|grant) prio <= grant[0];
    end
endmodule

// File: rtl/shared_onchip_memory.sv
// shared_onchip_memory: two slave ports sharing one single-port RAM through a round-robin arbiter.
// Define SHARED_ONCHIP_MEMORY_OUTREG_EN for an extra output register (read latency 2).
module shared_onchip_memory
    import shared_onchip_memory_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 8192,
    parameter string INIT_FILE = "shared_onchip_memory.hex",
    localparam int   ADDR_W    = $clog2(DEPTH),
    localparam int   BE_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clken,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic              s1_waitrequest,
    input  logic [ADDR_W-1:0] s2_address,
    input  logic [BE_W-1:0]   s2_byteenable,
    input  logic              s2_chipselect,
    input  logic              s2_read,
    input  logic              s2_write,
    input  logic [DATA_W-1:0] s2_writedata,
    output logic [DATA_W-1:0] s2_readdata,
    output logic              s2_readdatavalid,
    output logic              s2_waitrequest
);
    logic [NUM_PORTS-1:0] rd, wr, req, grant, src_v, rv;
    logic [ADDR_W-1:0]    addr  [NUM_PORTS];
    logic [BE_W-1:0]      be    [NUM_PORTS];
    logic [DATA_W-1:0]    wd    [NUM_PORTS];
    logic [DATA_W-1:0]    rdata [NUM_PORTS];
    logic [DATA_W-1:0]    mem   [DEPTH];
    logic [DATA_W-1:0]    src_d;
    logic [ADDR_W-1:0]    a;
    port_idx_t            sel;
    logic                 wr_acc, rd_acc;

    assign rd    = {s2_chipselect & s2_read, s1_chipselect & s1_read};
    assign wr    = {s2_chipselect & s2_write, s1_chipselect & s1_write};
    assign req   = rd | wr;
    assign addr  = '{s1_address, s2_address};
    assign be    = '{s1_byteenable, s2_byteenable};
    assign wd    = '{s1_writedata, s2_writedata};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (clken),
        .req     (req),
        .grant   (grant)
    );

    // read with write also set is a write and produces no readdatavalid
    assign sel    = grant[1];
    assign a      = addr[sel];
    assign wr_acc = (|grant) & wr[sel];
    assign rd_acc = (|grant) & rd[sel] & ~wr[sel];

    // RAM has no reset so its contents survive reset_n
    always_ff @(posedge clk) begin
        if (wr_acc)
            for (int b = 0; b < BE_W; b++)
                if (be[sel][b]) mem[a][8*b +: 8] <= wd[sel][8*b +: 8];
    end

`ifdef SHARED_ONCHIP_MEMORY_OUTREG_EN
    logic [NUM_PORTS-1:0] v1;
    logic [DATA_W-1:0]    d1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= '0;
            d1 <= '0;
        end else if (clken) begin
            v1 <= rd_acc ? grant : '0;
            if (rd_acc) d1 <= mem[a];
        end
    end
    assign src_v = v1;
    assign src_d = d1;
`else
    assign src_v = rd_acc ? grant : '0;
    assign src_d = mem[a];
`endif

    // per-port data registers hold the last returned word until that port's next read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rv <= '0;
            for (int n = 0; n < NUM_PORTS; n++) rdata[n] <= '0;
        end else if (clken) begin
            rv <= src_v;
            for (int n = 0; n < NUM_PORTS; n++)
                if (src_v[n]) rdata[n] <= src_d;
        end
    end

    assign s1_readdata      = rdata[0];
    assign s2_readdata      = rdata[1];
    assign s1_readdatavalid = rv[0] & clken;
    assign s2_readdatavalid = rv[1] & clken;
    assign s1_waitrequest   = req[0] & ~grant[0];
    assign s2_waitrequest   = req[1] & ~grant[1];
endmodule

// File: tb/tb_shared_onchip_memory.sv
// tb_shared_onchip_memory: directed self-checking bench for shared_onchip_memory.
module tb_shared_onchip_memory;
    import shared_onchip_memory_pkg::*;
    localparam int DW = 32, DEPTH = 64, AW = 6;
`ifdef SHARED_ONCHIP_MEMORY_OUTREG_EN
    localparam int LAT = READ_LATENCY_OUTREG;
`else
    localparam int LAT = READ_LATENCY_BASE;
`endif

    logic clk = 0, reset_n = 0, clken = 1;
    logic [AW-1:0] s1_address, s2_address;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic          s1_readdatavalid, s1_waitrequest, s2_readdatavalid, s2_waitrequest;
    int checks = 0, passes = 0;

    always #5 clk = ~clk;

    shared_onchip_memory #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        if (p == 1) begin
            s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
            s1_address = a; s1_byteenable = be; s1_writedata = wd;
        end else begin
            s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
            s2_address = a; s2_byteenable = be; s2_writedata = wd;
        end
    endtask

    function automatic logic wait_of(input int p);
        return p == 1 ? s1_waitrequest : s2_waitrequest;
    endfunction
    function automatic logic valid_of(input int p);
        return p == 1 ? s1_readdatavalid : s2_readdatavalid;
    endfunction
    function automatic logic [31:0] data_of(input int p);
        return p == 1 ? s1_readdata : s2_readdata;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_port(1, 0, 0, '0, '0, '0);
        set_port(2, 0, 0, '0, '0, '0);
    endtask

    task automatic do_write(input int p, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
        set_port(p, 0, 1, a, be, wd);
        @(negedge clk);
        check("wr_wait", wait_of(p), 0);
        tick();
        set_port(p, 0, 0, '0, '0, '0);
    endtask

    task automatic do_read(input int p, input logic [AW-1:0] a, input logic [31:0] exp);
        set_port(p, 1, 0, a, '0, '0);
        @(negedge clk);
        check("rd_wait", wait_of(p), 0);
        tick();
        set_port(p, 0, 0, '0, '0, '0);
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            check("rd_early_valid", valid_of(p), 0);
            tick();
        end
        @(negedge clk);
        check("rd_valid", valid_of(p), 1);
        check("rd_data", data_of(p), exp);
        check("rd_other_valid", valid_of(3 - p), 0);
        tick();
        @(negedge clk);
        check("rd_pulse_end", valid_of(p), 0);
        tick();
    endtask

    initial begin
        int v1 = 0, v2 = 0;
        idle();
        set_port(2, 1, 0, 6'd5, '0, '0);
        @(negedge clk);
        check("rst_s1_valid", s1_readdatavalid, 0);
        check("rst_s2_valid", s2_readdatavalid, 0);
        check("rst_s1_data", s1_readdata, 0);
        check("rst_s2_data", s2_readdata, 0);
        check("rst_s2_wait", s2_waitrequest, 1);
        tick();
        reset_n = 1;
        idle();
        tick();

        // write on s1, read back on s2
        do_write(1, 6'd5, 4'hF, 32'hDEADBEEF);
        do_read(2, 6'd5, 32'hDEADBEEF);
        // single-lane write followed immediately by a read
        do_write(1, 6'd5, 4'h1, 32'h00000011);
        do_read(1, 6'd5, 32'hDEADBE11);

        // read+write together acts as a write with no readdatavalid
        do_write(1, 6'd12, 4'hF, 32'hAABBCCDD);
        set_port(1, 1, 1, 6'd12, 4'b0110, 32'h12345678);
        @(negedge clk);
        check("rw_wait", s1_waitrequest, 0);
        tick();
        idle();
        for (int j = 0; j <= LAT; j++) begin
            @(negedge clk);
            check("rw_no_valid", s1_readdatavalid, 0);
            tick();
        end
        do_read(1, 6'd12, 32'hAA3456DD);

        // contention: last accept on s2, so s1 wins the first tie
        do_write(1, 6'd10, 4'hF, 32'hA0A0A0A0);
        do_write(2, 6'd11, 4'hF, 32'hB1B1B1B1);
        set_port(1, 1, 0, 6'd10, '0, '0);
        set_port(2, 1, 0, 6'd11, '0, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rr_s1_wait_%0d", i), s1_waitrequest, i % 2);
            check($sformatf("rr_s2_wait_%0d", i), s2_waitrequest, (i + 1) % 2);
            v1 += int'(s1_readdatavalid);
            v2 += int'(s2_readdatavalid);
            tick();
        end
        idle();
        for (int j = 0; j <= LAT; j++) begin
            @(negedge clk);
            v1 += int'(s1_readdatavalid);
            v2 += int'(s2_readdatavalid);
            tick();
        end
        check("rr_s1_pulses", v1, 3);
        check("rr_s2_pulses", v2, 3);
        check("rr_s1_data", s1_readdata, 32'hA0A0A0A0);
        check("rr_s2_data", s2_readdata, 32'hB1B1B1B1);

        // reset right after an accepted s2 read drops it
        set_port(2, 1, 0, 6'd5, '0, '0);
        @(negedge clk);
        check("rst_rd_wait", s2_waitrequest, 0);
        tick();
        idle();
        reset_n = 0;
        set_port(1, 1, 0, 6'd5, '0, '0);
        @(negedge clk);
        check("rst_drop_valid", s2_readdatavalid, 0);
        check("rst_clear_data", s2_readdata, 0);
        check("rst_wait_follows_req", s1_waitrequest, 1);
        tick();
        reset_n = 1;
        idle();
        for (int j = 0; j <= LAT; j++) begin
            @(negedge clk);
            check("rst_no_late_valid", s2_readdatavalid, 0);
            tick();
        end
        set_port(1, 1, 0, 6'd5, '0, '0);
        set_port(2, 1, 0, 6'd5, '0, '0);
        @(negedge clk);
        check("post_rst_s1_wait", s1_waitrequest, 0);
        check("post_rst_s2_wait", s2_waitrequest, 1);
        tick();
        @(negedge clk);
        check("post_rst_s2_wait2", s2_waitrequest, 0);
        tick();
        idle();
        for (int j = 0; j <= LAT; j++) tick();
        @(negedge clk);
        check("post_rst_s1_data", s1_readdata, 32'hDEADBE11);
        check("post_rst_s2_data", s2_readdata, 32'hDEADBE11);
        tick();

        // clken low stalls the request
        clken = 0;
        set_port(1, 1, 0, 6'd12, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("clken_wait_%0d", i), s1_waitrequest, 1);
            check($sformatf("clken_valid_%0d", i), s1_readdatavalid, 0);
            tick();
        end
        clken = 1;
        @(negedge clk);
        check("clken_accept", s1_waitrequest, 0);
        tick();
        idle();
        for (int i = 1; i < LAT; i++) tick();
        @(negedge clk);
        check("clken_valid", s1_readdatavalid, 1);
        check("clken_data", s1_readdata, 32'hAA3456DD);
        tick();

        // back-to-back reads of addresses 0 and 1
        do_write(1, 6'd0, 4'hF, 32'h00000100);
        do_write(1, 6'd1, 4'hF, 32'h00000101);
        for (int k = 0; k <= LAT + 2; k++) begin
            if (k == 0) set_port(1, 1, 0, 6'd0, '0, '0);
            else if (k == 1) set_port(1, 1, 0, 6'd1, '0, '0);
            else idle();
            @(negedge clk);
            if (k < 2) check($sformatf("b2b_wait_%0d", k), s1_waitrequest, 0);
            check($sformatf("b2b_valid_%0d", k), s1_readdatavalid, (k == LAT || k == LAT + 1) ? 1 : 0);
            if (k == LAT) check("b2b_data0", s1_readdata, 32'h00000100);
            if (k == LAT + 1) check("b2b_data1", s1_readdata, 32'h00000101);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/shared_onchip_memory.md
SHARED_ONCHIP_MEMORY -- requirements
Module: shared_onchip_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 8192: number of words.
REQ-003 SHALL have parameter INIT_FILE, default "shared_onchip_memory.hex": RAM initial contents.
REQ-004 SHALL derive local ADDR_W = clog2(DEPTH) and BE_W = DATA_W/8.
REQ-005 SHALL have port clk, input, 1: single clock; one clock, all logic in this domain.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port clken, input, 1: global clock enable; low freezes all state.
REQ-008 SHALL have, per slave port sN (N = 1, 2), sN_address, input, ADDR_W: word address.
REQ-009 SHALL have sN_byteenable, input, BE_W: write byte lanes.
REQ-010 SHALL have sN_chipselect, sN_read and sN_write, inputs, 1 each: request qualifiers.
REQ-011 SHALL have sN_writedata, input, DATA_W: write data.
REQ-012 SHALL have sN_readdata, output, DATA_W: read data.
REQ-013 SHALL have sN_readdatavalid, output, 1: sN_readdata valid this cycle.
REQ-014 SHALL have sN_waitrequest, output, 1: request not accepted this cycle.

Function
REQ-015 SHALL define request reqN = sN_chipselect & (sN_read | sN_write); with read and write both high, the request SHALL be treated as a write with no readdatavalid.
REQ-016 SHALL accept at most one request per cycle into one single-port RAM; accept = grant & clken.
REQ-017 SHALL drive sN_waitrequest = reqN & ~(grantN & clken), combinationally.
REQ-018 SHALL arbitrate round-robin: a single requester is granted immediately; on a tie the port not granted last SHALL win.
REQ-019 SHALL grant a continuously requesting port within 2 cycles.
REQ-020 SHALL write only the byte lanes whose sN_byteenable bit is 1; other lanes are unchanged.
REQ-021 SHALL assert sN_readdatavalid exactly 1 cycle after an accepted read (base latency 1), for one cycle, only on the issuing port.
REQ-022 SHALL return newly written data to a read accepted in the cycle after a write to the same address.
REQ-023 SHALL hold sN_readdata stable until the next readdatavalid on that port.
REQ-024 SHALL, with clken low, issue no grants, freeze the pipeline and keep sN_readdatavalid at 0.
REQ-025 SHALL ignore address bits addressing beyond DEPTH-1, wrapping modulo DEPTH.

Reset
REQ-026 SHALL, on reset_n low, clear sN_readdatavalid to 0 and sN_readdata to 0, and set the arbiter priority to s1.
REQ-027 SHALL drop reads in flight at reset; no readdatavalid SHALL follow reset release for them.
REQ-028 SHALL preserve RAM contents across reset; INIT_FILE applies at configuration only.
REQ-029 SHALL issue no grant while reset_n is low, so waitrequest follows reqN.

Configuration
REQ-030 SHALL, with macro SHARED_ONCHIP_MEMORY_OUTREG_EN defined, add an output register stage, giving read latency 2; readdatavalid and readdata SHALL shift by one cycle, and accept rate SHALL be unchanged.
REQ-031 SHALL, without SHARED_ONCHIP_MEMORY_OUTREG_EN, have read latency 1 and no extra register.

Structure
REQ-032 SHALL place in package shared_onchip_memory_pkg: NUM_PORTS = 2, the READ_LATENCY constants (1 and 2), and the port-index typedef.
REQ-033 SHALL implement arbitration in sub-module rr_arbiter2, with the priority pointer updated only on accept.
REQ-034 SHALL infer RAM from a behavioural array with per-byte write enables, with no vendor primitive.

Verification
REQ-035 SHALL cover: s1 writes 0xDEADBEEF to address 5 with byteenable 0xF, then s2 reads address 5 -> s2_readdatavalid 1 cycle after accept, data 0xDEADBEEF.
REQ-036 SHALL cover: address 5 holds 0xDEADBEEF, s1 writes 0x00000011 with byteenable 0x1, then reads -> 0xDEADBE11.
REQ-037 SHALL cover: s1 and s2 both read continuously for 6 cycles -> grants alternate s1, s2, s1 ...; each waitrequest is high on alternate cycles; 3 readdatavalid pulses per port.
REQ-038 SHALL cover: reset_n pulsed low one cycle after a s2 read is accepted -> no s2_readdatavalid; memory data still intact on a later read.
REQ-039 SHALL cover: clken low for 3 cycles while s1 requests -> s1_waitrequest high for 3 cycles; accepted on the first cycle clken is high.
REQ-040 SHALL cover: with SHARED_ONCHIP_MEMORY_OUTREG_EN, a back-to-back read of addresses 0 then 1 -> readdatavalid 2 cycles after each accept, in order.
